audioplay_sample_reader: RTL and testbench

AUDIOPLAY_SAMPLE_READER -- requirements
Module: audioplay_sample_reader

---
 rtl/audioplay_pkg.sv | 27 ++
 rtl/audioplay_skid_fifo.sv | 53 +++++
 rtl/audioplay_sample_reader.sv | 133 +++++++++++++
 tb/tb_audioplay_sample_reader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audioplay_pkg.sv
// Shared widths, FSM encoding and sample layout for the audio playback reader.
package audioplay_pkg;

  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned RAM_DEPTH  = 2048;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } sample_t;

  // Word address after a, wrapping through the top of the RAM.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return ADDR_W'((32'(a) + 32'd1) % RAM_DEPTH);
  endfunction

endpackage

// File: rtl/audioplay_skid_fifo.sv
// Two-entry FIFO holding returned RAM words until the sample consumer takes them.
module audioplay_skid_fifo
  import audioplay_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= CNT_W'(count + CNT_W'(do_push) - CNT_W'(do_pop));
    end
  end

endmodule

// File: rtl/audioplay_sample_reader.sv
// Streams stereo sample words from a RAM window to a valid/ready sink.
// Optional AUDIOPLAY_READER_LOOP_EN adds a loop input that replays the window.
module audioplay_sample_reader
  import audioplay_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   end_addr,
`ifdef AUDIOPLAY_READER_LOOP_EN
  input  logic                loop,
`endif
  output logic [ADDR_W-1:0]   address,
  output logic                chipselect,
  output logic                write,
  output logic [3:0]          byteenable,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata,
  output logic [SAMPLE_W-1:0] smp_left,
  output logic [SAMPLE_W-1:0] smp_right,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic                busy,
  output logic                done
);

  state_e            state;
  state_e            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] end_q;
  logic              inflight;
  logic              issue;
  logic              done_set;
  logic              pop;
  logic              push;
  logic              loop_now;
  logic              at_end;
  logic [CNT_W-1:0]  pending;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  sample_t           head;

`ifdef AUDIOPLAY_READER_LOOP_EN
  assign loop_now = loop;
`else
  assign loop_now = 1'b0;
`endif

  assign write      = 1'b0;
  assign byteenable = 4'hF;
  assign clken      = 1'b1;
  assign address    = ptr;
  assign chipselect = issue;
  assign smp_valid  = !fifo_empty;
  assign pop        = smp_valid && smp_ready;
  assign push       = inflight && !stop;
  assign at_end     = (ptr == end_q);
  assign head       = fifo_dout;
  assign smp_left   = head.left;
  assign smp_right  = head.right;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start && !stop) state_next = ST_RUN;
      ST_RUN: begin
        if (stop)                             state_next = ST_IDLE;
        else if (issue && at_end && !loop_now) state_next = ST_DRAIN;
      end
      ST_DRAIN: if (stop || done_set) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Occupancy is counted after this cycle's pop so a steady stream keeps one read per cycle.
  always_comb begin
    issue    = 1'b0;
    done_set = 1'b0;
    pending  = CNT_W'(fifo_count - CNT_W'(pop)) + CNT_W'(inflight);
    case (state)
      ST_RUN:   issue = !reset && !stop && (pending < CNT_W'(FIFO_DEPTH))
                        && !(fifo_full && !pop);
      ST_DRAIN: done_set = !reset && !stop && (pending == '0);
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      base_q   <= '0;
      end_q    <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= done_set;
      busy     <= (state_next != ST_IDLE);
      if (state == ST_IDLE && start && !stop) begin
        base_q <= base_addr;
        end_q  <= end_addr;
        ptr    <= base_addr;
      end else if (issue) begin
        ptr <= (at_end && loop_now) ? base_q : next_addr(ptr);
      end
    end
  end

  audioplay_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (stop),
    .push  (push),
    .pop   (pop),
    .din   (readdata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_audioplay_sample_reader.sv
// Scoreboard bench for audioplay_sample_reader: expected reads and samples are queued
// at start, a negedge monitor checks every read strobe, transfer and done pulse.
module tb_audioplay_sample_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [10:0] base_addr;
  logic [10:0] end_addr;
`ifdef AUDIOPLAY_READER_LOOP_EN
  logic        loop;
`endif
  logic [10:0] address;
  logic        chipselect;
  logic        write;
  logic [3:0]  byteenable;
  logic        clken;
  logic [31:0] readdata;
  logic [15:0] smp_left;
  logic [15:0] smp_right;
  logic        smp_valid;
  logic        smp_ready;
  logic        busy;
  logic        done;

  logic [31:0] ram [2048];
  logic [10:0] exp_addr [$];
  logic [31:0] exp_data [$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cs_count = 0;
  int xfer_count = 0;
  int done_count = 0;
  int first_cs, last_cs, first_xfer, last_xfer;
  int outstanding = 0;
  bit expect_done = 0;
  bit held = 0;
  bit rand_ready = 0;
  logic [31:0] held_data;
  logic [31:0] last_sample;

  audioplay_sample_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .base_addr  (base_addr),
    .end_addr   (end_addr),
`ifdef AUDIOPLAY_READER_LOOP_EN
    .loop       (loop),
`endif
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .byteenable (byteenable),
    .clken      (clken),
    .readdata   (readdata),
    .smp_left   (smp_left),
    .smp_right  (smp_right),
    .smp_valid  (smp_valid),
    .smp_ready  (smp_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM port model: word appears one cycle after the strobe, junk otherwise.
  always @(posedge clk) readdata <= chipselect ? ram[address] : $urandom();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      held = 0;
    end else begin
      if (stop) check("cs_during_stop", 32'(chipselect), 32'd0);
      if (held) begin
        check("hold_valid", 32'(smp_valid), 32'd1);
        check("hold_data", {smp_left, smp_right}, held_data);
      end
      if (smp_valid && smp_ready) begin
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        xfer_count++;
        outstanding--;
        last_sample = {smp_left, smp_right};
        if (exp_data.size() == 0) fail_now("unexpected_sample");
        else check("sample", {smp_left, smp_right}, exp_data.pop_front());
      end
      if (chipselect) begin
        if (first_cs < 0) first_cs = cyc;
        last_cs = cyc;
        cs_count++;
        outstanding++;
        check("busy_on_read", 32'(busy), 32'd1);
        check("outstanding_le2", 32'(outstanding <= 2), 32'd1);
        if (exp_addr.size() == 0) fail_now("unexpected_read");
        else check("read_addr", 32'(address), 32'(exp_addr.pop_front()));
      end
      if (done) begin
        done_count++;
        check("done_expected", 32'(expect_done), 32'd1);
        check("done_latency", 32'(cyc - last_xfer), 32'd1);
        check("done_all_data", 32'(exp_data.size()), 32'd0);
        expect_done = 0;
      end
      held = smp_valid && !smp_ready && !stop;
      held_data = {smp_left, smp_right};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) smp_ready = ($urandom() % 4) != 0;
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_cs"}, 32'(chipselect), 32'd0);
    check({tag, "_valid"}, 32'(smp_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_addr"}, 32'(address), 32'd0);
    check({tag, "_left"}, 32'(smp_left), 32'd0);
    check({tag, "_right"}, 32'(smp_right), 32'd0);
  endtask

  // Expected reads: addresses base..end inclusive, wrapping mod 2048, repeated reps times.
  task automatic queue_run(input logic [10:0] b, input logic [10:0] e, input int reps);
    int n;
    logic [10:0] a;
    n = int'(11'(e - b)) + 1;
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < n; i++) begin
        a = 11'(b + 11'(i));
        exp_addr.push_back(a);
        exp_data.push_back(ram[a]);
      end
  endtask

  task automatic pulse_start(input logic [10:0] b, input logic [10:0] e, output int c0);
    first_cs = -1;
    first_xfer = -1;
    outstanding = 0;
    @(posedge clk);
    #1;
    c0 = cyc;
    base_addr = b;
    end_addr = e;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 400 && done_count == d0; k++) begin
      @(posedge clk);
      #1;
    end
    check("run_done", 32'(done_count - d0), 32'd1);
    check("idle_after_run", 32'(busy), 32'd0);
    check("reads_all_issued", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic run(input logic [10:0] b, input logic [10:0] e, output int c0);
    int d0;
    d0 = done_count;
    queue_run(b, e, 1);
    expect_done = 1;
    pulse_start(b, e, c0);
    wait_done(d0);
  endtask

  task automatic do_stop();
    int d0;
    int s0;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    expect_done = 0;
    outstanding = 0;
    check("stop_valid", 32'(smp_valid), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_cs", 32'(chipselect), 32'd0);
    d0 = done_count;
    s0 = xfer_count;
    repeat (4) @(posedge clk);
    #1;
    check("stop_no_done", 32'(done_count - d0), 32'd0);
    check("stop_no_sample", 32'(xfer_count - s0), 32'd0);
  endtask

  task automatic run_stop(input logic [10:0] b, input logic [10:0] e, input int delay);
    int c0;
    queue_run(b, e, 1);
    pulse_start(b, e, c0);
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    do_stop();
  endtask

  initial begin
    int c0;
    int cs0;
    logic [10:0] b;
    int len;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    base_addr = '0;
    end_addr = '0;
    smp_ready = 1'b1;
`ifdef AUDIOPLAY_READER_LOOP_EN
    loop = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) ram[i] = $urandom();
    ram[11'h100] = 32'hAAAA5555;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle_zero("reset");
    check("write_const", 32'(write), 32'd0);
    check("byteenable_const", 32'(byteenable), 32'hF);
    check("clken_const", 32'(clken), 32'd1);

    // Straight run with the sink always ready: back-to-back reads and samples.
    run(11'h010, 11'h013, c0);
    check("first_read_cycle", 32'(first_cs - c0), 32'd1);
    check("read_burst_span", 32'(last_cs - first_cs), 32'd3);
    check("first_sample_lat", 32'(first_xfer - first_cs), 32'd2);
    check("sample_burst_span", 32'(last_xfer - first_xfer), 32'd3);

    // Window wrapping through the top of the RAM.
    cs0 = cs_count;
    run(11'h7FE, 11'h001, c0);
    check("wrap_reads", 32'(cs_count - cs0), 32'd4);

    // Single-word window.
    cs0 = xfer_count;
    run(11'h100, 11'h100, c0);
    check("one_word_count", 32'(xfer_count - cs0), 32'd1);
    check("one_word_left", 32'(last_sample[31:16]), 32'h0000AAAA);
    check("one_word_right", 32'(last_sample[15:0]), 32'h00005555);

    // Sink stalls for 5 cycles mid-run.
    fork
      run(11'h200, 11'h20B, c0);
      begin
        repeat (5) @(posedge clk);
        #1;
        smp_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        smp_ready = 1'b1;
      end
    join

    // Abort one cycle after the first read.
    run_stop(11'h300, 11'h30F, 1);

    // start together with stop in IDLE is ignored.
    cs0 = cs_count;
    @(posedge clk);
    #1;
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    check("start_stop_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("start_stop_no_read", 32'(cs_count - cs0), 32'd0);

    // Reset mid-run beats simultaneous start and stop.
    queue_run(11'h400, 11'h40F, 1);
    pulse_start(11'h400, 11'h40F, c0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    expect_done = 0;
    outstanding = 0;
    check_idle_zero("midrun_reset");
    cs0 = cs_count;
    repeat (3) @(posedge clk);
    #1;
    check("reset_no_read", 32'(cs_count - cs0), 32'd0);

    // Random windows, random sink backpressure, occasional early abort.
    rand_ready = 1;
    for (int t = 0; t < 25; t++) begin
      b = 11'($urandom_range(0, 2047));
      len = $urandom_range(1, 8);
      if (len >= 4 && ($urandom() % 4) == 0)
        run_stop(b, 11'(b + 11'(len - 1)), $urandom_range(0, 2));
      else
        run(b, 11'(b + 11'(len - 1)), c0);
    end
    rand_ready = 0;
    smp_ready = 1'b1;

`ifdef AUDIOPLAY_READER_LOOP_EN
    // Loop the 2-word window, then release loop and expect termination after 0x021.
    begin
      int d0;
      d0 = done_count;
      loop = 1'b1;
      queue_run(11'h020, 11'h021, 3);
      expect_done = 1;
      cs0 = cs_count;
      pulse_start(11'h020, 11'h021, c0);
      for (int k = 0; k < 50 && (cs_count - cs0) < 5; k++) begin
        @(posedge clk);
        #1;
      end
      check("loop_no_early_done", 32'(done_count - d0), 32'd0);
      loop = 1'b0;
      wait_done(d0);
      check("loop_read_total", 32'(cs_count - cs0), 32'd6);
    end
`endif

    check("final_exp_empty", 32'(exp_data.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
